// File: rtl/rr_arb_pkg.sv
// rtl/rr_arb_pkg.sv - shared types and width helpers for the round-robin arbiter
package rr_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Counter only needs to reach max_hold-1 before the watchdog fires.
    function automatic int hold_width(input int max_hold);
        return (max_hold > 2) ? $clog2(max_hold) : 1;
    endfunction

endpackage

// File: rtl/rr_prio_pick.sv
// rtl/rr_prio_pick.sv - combinational first-one search starting at a rotating pointer
module rr_prio_pick
    import rr_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IW    = idx_width(N_REQ)
) (
    input  logic [N_REQ-1:0] cand_i,
    input  logic [IW-1:0]    start_i,
    output logic [N_REQ-1:0] win_o,
    output logic [IW-1:0]    win_idx_o,
    output logic             any_o
);

    logic [2*N_REQ-1:0] dbl;
    logic [N_REQ-1:0]   rot;
    logic [N_REQ-1:0]   one;
    logic [IW-1:0]      off;
    logic [IW:0]        sum;
    logic               found;

    always_comb begin
        dbl       = {cand_i, cand_i} >> start_i;
        rot       = dbl[N_REQ-1:0];
        one       = {{(N_REQ-1){1'b0}}, 1'b1};
        off       = '0;
        found     = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!found && rot[k]) begin
                found = 1'b1;
                off   = IW'(k);
            end
        end
        // Undo the rotation: winner index is start + offset, modulo N_REQ.
        sum = {1'b0, start_i} + {1'b0, off};
        if (sum >= (IW+1)'(N_REQ)) begin
            sum = sum - (IW+1)'(N_REQ);
        end
        any_o     = found;
        win_idx_o = found ? sum[IW-1:0] : '0;
        win_o     = found ? (one << win_idx_o) : '0;
    end

endmodule

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter with held grants; RR_ARB_WATCHDOG_EN adds a hold-time revoke
module rr_arbiter
    import rr_arb_pkg::*;
#(
    parameter  int N_REQ    = 4,
    parameter  int MAX_HOLD = 16,
    localparam int IW       = idx_width(N_REQ)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [N_REQ-1:0] req_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [IW-1:0]    gnt_idx_o,
    output logic             gnt_valid_o,
    output logic             timeout_o
);

    if (N_REQ < 2 || MAX_HOLD < 2) begin : g_bad_params
        $error("rr_arbiter: N_REQ and MAX_HOLD must both be at least 2");
    end

    arb_state_e       state_q, state_d;
    logic [IW-1:0]    ptr_q, ptr_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             valid_q, valid_d;

    logic             owner_req;
    logic             revoke;
    logic             rel;
    logic [IW-1:0]    ptr_next_owner;
    logic [N_REQ-1:0] cand;
    logic [IW-1:0]    start;
    logic [N_REQ-1:0] win;
    logic [IW-1:0]    win_idx;
    logic             win_any;

    assign owner_req      = req_i[idx_q];
    assign rel            = (state_q == BUSY) && (!owner_req || revoke);
    assign ptr_next_owner = (idx_q == IW'(N_REQ-1)) ? '0 : idx_q + IW'(1);

    // When re-arbitrating from BUSY the outgoing owner is masked out and the search starts after it.
    assign cand  = (state_q == BUSY) ? (req_i & ~gnt_q) : req_i;
    assign start = (state_q == BUSY) ? ptr_next_owner : ptr_q;

    rr_prio_pick #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_pick (
        .cand_i    (cand),
        .start_i   (start),
        .win_o     (win),
        .win_idx_o (win_idx),
        .any_o     (win_any)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (win_any) begin
                    gnt_d   = win;
                    idx_d   = win_idx;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (rel) begin
                    ptr_d = ptr_next_owner;
                    if (win_any) begin
                        gnt_d = win;
                        idx_d = win_idx;
                    end else begin
                        gnt_d   = '0;
                        idx_d   = '0;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                gnt_d   = '0;
                idx_d   = '0;
                state_d = IDLE;
            end
        endcase
        valid_d = |gnt_d;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            gnt_q   <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
        end
    end

`ifdef RR_ARB_WATCHDOG_EN
    localparam int CW = hold_width(MAX_HOLD);

    logic [CW-1:0] hold_q;
    logic          timeout_q;

    assign revoke = (state_q == BUSY) && owner_req && (hold_q == CW'(MAX_HOLD-1));

    // Any grant change (new owner, release, idle) restarts the count.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            hold_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= revoke;
            if (state_q == BUSY && !rel) begin
                hold_q <= hold_q + CW'(1);
            end else begin
                hold_q <= '0;
            end
        end
    end

    assign timeout_o = timeout_q;
`else
    assign revoke    = 1'b0;
    assign timeout_o = 1'b0;
`endif

    assign gnt_o       = gnt_q;
    assign gnt_idx_o   = idx_q;
    assign gnt_valid_o = valid_q;

endmodule

// File: tb/tb_rr_arbiter.sv
// tb/tb_rr_arbiter.sv - self-checking bench for rr_arbiter against a behavioural round-robin model
module tb_rr_arbiter;

    localparam int N    = 4;
    localparam int MAXH = 16;
`ifdef RR_ARB_WATCHDOG_EN
    localparam bit WD = 1'b1;
`else
    localparam bit WD = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] req = '0;
    logic [N-1:0] gnt;
    logic [1:0]   gnt_idx;
    logic         gnt_valid;
    logic         timeout;

    int n_cmp = 0;
    int n_bad = 0;

    int m_owner = -1;
    int m_ptr   = 0;
    int m_hold  = 0;
    bit m_to    = 1'b0;

    rr_arbiter #(
        .N_REQ    (N),
        .MAX_HOLD (MAXH)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_i       (req),
        .gnt_o       (gnt),
        .gnt_idx_o   (gnt_idx),
        .gnt_valid_o (gnt_valid),
        .timeout_o   (timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [N-1:0] c, input int from);
        for (int k = 0; k < N; k++) begin
            if (c[(from + k) % N]) return (from + k) % N;
        end
        return -1;
    endfunction

    task automatic model_step(input logic [N-1:0] r, input logic rs);
        bit           expire;
        logic [N-1:0] others;
        if (!rs) begin
            m_owner = -1; m_ptr = 0; m_hold = 0; m_to = 1'b0;
            return;
        end
        m_to = 1'b0;
        if (m_owner < 0) begin
            m_owner = pick(r, m_ptr);
            m_hold  = 0;
        end else begin
            expire = WD && r[m_owner] && (m_hold == MAXH - 1);
            if (!r[m_owner] || expire) begin
                m_to    = expire;
                m_ptr   = (m_owner + 1) % N;
                others  = r;
                others[m_owner] = 1'b0;
                m_owner = pick(others, m_ptr);
                m_hold  = 0;
            end else begin
                m_hold++;
            end
        end
    endtask

    task automatic check_model();
        logic [N-1:0] eg;
        eg = '0;
        if (m_owner >= 0) eg[m_owner] = 1'b1;
        chk("gnt", 32'(gnt), 32'(eg));
        chk("gnt_idx", 32'(gnt_idx), (m_owner >= 0) ? 32'(m_owner) : 32'd0);
        chk("gnt_valid", 32'(gnt_valid), 32'(m_owner >= 0));
        chk("timeout", 32'(timeout), 32'(m_to));
    endtask

    // Drive one cycle of inputs, advance the model, then sample 1 time unit after the edge.
    task automatic cyc(input logic [N-1:0] r, input logic rs);
        req   = r;
        rst_n = rs;
        model_step(r, rs);
        @(posedge clk);
        #1;
        check_model();
    endtask

    initial begin
        logic [N-1:0] r;

        cyc(4'b0000, 1'b0);
        cyc(4'b0000, 1'b0);
        chk("reset_gnt", 32'(gnt), 32'h0);
        chk("reset_valid", 32'(gnt_valid), 32'h0);

        cyc(4'b1010, 1'b1);
        chk("t1_gnt", 32'(gnt), 32'b0010);
        chk("t1_idx", 32'(gnt_idx), 32'd1);

        cyc(4'b0000, 1'b0);
        cyc(4'b1111, 1'b1);
        chk("t2_first", 32'(gnt), 32'b0001);
        cyc(4'b1111, 1'b1);
        cyc(4'b1110, 1'b1);
        chk("t2_second", 32'(gnt), 32'b0010);
        cyc(4'b1111, 1'b1);
        cyc(4'b1101, 1'b1);
        chk("t2_third", 32'(gnt), 32'b0100);

        cyc(4'b1111, 1'b1);
        cyc(4'b1011, 1'b1);
        chk("t3_owner3", 32'(gnt_idx), 32'd3);
        cyc(4'b1011, 1'b1);
        cyc(4'b0001, 1'b1);
        chk("t3_wrap", 32'(gnt), 32'b0001);

        cyc(4'b0000, 1'b0);
        cyc(4'b0100, 1'b1);
        cyc(4'b0100, 1'b1);
        cyc(4'b0000, 1'b1);
        chk("t4_drop", 32'(gnt), 32'h0);
        cyc(4'b0000, 1'b1);
        cyc(4'b0100, 1'b1);
        chk("t4_regrant", 32'(gnt), 32'b0100);

        cyc(4'b0100, 1'b0);
        chk("t5_reset_gnt", 32'(gnt), 32'h0);
        chk("t5_reset_idx", 32'(gnt_idx), 32'h0);
        cyc(4'b1111, 1'b1);
        chk("t5_from0", 32'(gnt), 32'b0001);

        cyc(4'b0000, 1'b0);
        cyc(4'b0011, 1'b1);
        for (int i = 0; i < MAXH - 1; i++) cyc(4'b0011, 1'b1);
        chk("t6_held", 32'(gnt), 32'b0001);
        cyc(4'b0011, 1'b1);
        chk("t6_after16", 32'(gnt), WD ? 32'b0010 : 32'b0001);
        chk("t6_timeout", 32'(timeout), WD ? 32'd1 : 32'd0);
        for (int i = 0; i < 20; i++) cyc(4'b0011, 1'b1);

        r = '0;
        for (int i = 0; i < 1500; i++) begin
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(3) == 0) r[b] = ~r[b];
            end
            cyc(r, ($urandom_range(63) != 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
